// File: rtl/if_stage_if.sv
// Fetch-side memory bus for if_stage.
// The master drives the request; the slave returns the data.
interface if_stage_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] Mem_Addr;
  logic              Mem_Req;
  logic              Mem_Ack;
  logic [DATA_W-1:0] Mem_Data;

  modport master (
    output Mem_Addr,
    output Mem_Req,
    input  Mem_Ack,
    input  Mem_Data
  );

  modport slave (
    input  Mem_Addr,
    input  Mem_Req,
    output Mem_Ack,
    output Mem_Data
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, memory fetch handshake, IR write.
// Optional IF_FETCH_CNT_EN adds a saturating Fetch_Cnt output.
module if_stage #(
  parameter int                 DATA_W      = 32,
  parameter logic [DATA_W-1:0]  RESET_PC    = '0,
  parameter int                 MEM_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PC_LdEn,
  input  logic              PC_Sel,
  input  logic [DATA_W-1:0] Branch_Imm,
  if_stage_if.master        mem,
  output logic [DATA_W-1:0] IR_Data,
  output logic              IR_WE,
  output logic [DATA_W-1:0] PC,
  output logic              Busy,
  output logic              Fetch_Err
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [15:0]       Fetch_Cnt
`endif
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    READY = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [7:0]        wait_q, wait_d;
  logic [7:0]        wait_inc;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] pc_branch;

  assign wait_inc  = wait_q + 8'd1;
  assign pc_plus4  = pc_q + DATA_W'(4);
  assign pc_branch = pc_plus4 + (Branch_Imm << 2);

  // Next state, PC, IR capture and wait counter.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (mem.Mem_Ack) begin
          ir_d    = mem.Mem_Data;
          wait_d  = '0;
          state_d = LOAD;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TMO) begin
            state_d = ERR;
          end
        end
      end
      LOAD: begin
        state_d = READY;
      end
      READY: begin
        if (PC_LdEn) begin
          pc_d    = PC_Sel ? pc_branch : pc_plus4;
          wait_d  = '0;
          state_d = FETCH;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = ERR;
      end
    endcase
  end

  // State, PC, IR and wait counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    mem.Mem_Req = 1'b0;
    IR_WE       = 1'b0;
    Busy        = 1'b1;
    Fetch_Err   = 1'b0;
    unique case (state_q)
      FETCH:   mem.Mem_Req = 1'b1;
      LOAD:    IR_WE       = 1'b1;
      READY:   Busy        = 1'b0;
      ERR:     Fetch_Err   = 1'b1;
      default: ;
    endcase
  end

  assign mem.Mem_Addr = pc_q;
  assign PC           = pc_q;
  assign IR_Data      = ir_q;

`ifdef IF_FETCH_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  // Count completed fetches; saturate rather than wrap.
  always_comb begin
    fcnt_d = fcnt_q;
    if (state_q == LOAD && fcnt_q != 16'hFFFF) begin
      fcnt_d = fcnt_q + 16'd1;
    end
  end

  // Fetch counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign Fetch_Cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage.
// Second instance checks PC wrap from a high RESET_PC.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, ld, sel;
  logic [31:0] imm;
  logic [31:0] ir;
  logic        we, busy, err;
  logic [31:0] pc;
  logic        rst2, ld2;
  logic [31:0] ir2, pc2;
  logic        we2, busy2, err2;
`ifdef IF_FETCH_CNT_EN
  logic [15:0] fcnt, fcnt2;
`endif
  int errors = 0;
  int checks = 0;

  if_stage_if m0 ();
  if_stage_if m1 ();

  always #5 clk = ~clk;

  if_stage dut (
    .CLK(clk), .RST(rst), .PC_LdEn(ld), .PC_Sel(sel),
    .Branch_Imm(imm), .mem(m0), .IR_Data(ir), .IR_WE(we),
    .PC(pc), .Busy(busy), .Fetch_Err(err)
`ifdef IF_FETCH_CNT_EN
    , .Fetch_Cnt(fcnt)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .CLK(clk), .RST(rst2), .PC_LdEn(ld2), .PC_Sel(1'b0),
    .Branch_Imm(32'd0), .mem(m1), .IR_Data(ir2), .IR_WE(we2),
    .PC(pc2), .Busy(busy2), .Fetch_Err(err2)
`ifdef IF_FETCH_CNT_EN
    , .Fetch_Cnt(fcnt2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  // Called at a negedge while in FETCH: ack now, check LOAD then READY.
  task automatic fetch_ok(input logic [31:0] d, input logic [31:0] a);
    chk("fetch_req", 32'(m0.Mem_Req), 32'd1);
    chk("fetch_addr", m0.Mem_Addr, a);
    m0.Mem_Ack  = 1'b1;
    m0.Mem_Data = d;
    step;
    m0.Mem_Ack = 1'b0;
    chk("load_we", 32'(we), 32'd1);
    chk("load_ir", ir, d);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_req", 32'(m0.Mem_Req), 32'd0);
    step;
    chk("ready_we", 32'(we), 32'd0);
    chk("ready_busy", 32'(busy), 32'd0);
    chk("ready_ir", ir, d);
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; sel = 1'b0; imm = '0;
    m0.Mem_Ack = 1'b0; m0.Mem_Data = '0;
    rst2 = 1'b1; ld2 = 1'b0;
    m1.Mem_Ack = 1'b0; m1.Mem_Data = '0;
    step; step;
    chk("rst_req", 32'(m0.Mem_Req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_pc", pc, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
`ifdef IF_FETCH_CNT_EN
    chk("rst_fcnt", 32'(fcnt), 32'd0);
`endif
    rst = 1'b0;
    step;
    fetch_ok(32'h5432, 32'd0);

    ld = 1'b1; sel = 1'b0;
    step;
    ld = 1'b0;
    chk("pc4", pc, 32'd4);
    ld = 1'b1;
    step;
    ld = 1'b0;
    chk("ld_fetch_pc", pc, 32'd4);
    chk("ld_fetch_req", 32'(m0.Mem_Req), 32'd1);
    m0.Mem_Ack = 1'b1; m0.Mem_Data = 32'h1234; ld = 1'b1;
    step;
    m0.Mem_Ack = 1'b0;
    chk("t2_we", 32'(we), 32'd1);
    chk("t2_ir", ir, 32'h1234);
    chk("t2_pc", pc, 32'd4);
    step;
    ld = 1'b0;
    chk("ld_load_pc", pc, 32'd4);
    chk("t2_we_off", 32'(we), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);

    ld = 1'b1;
    step;
    ld = 1'b0;
    chk("pc8", pc, 32'd8);
    fetch_ok(32'hAAAA, 32'd8);

    ld = 1'b1; sel = 1'b1; imm = 32'hFFFF_FFFE;
    step;
    ld = 1'b0; sel = 1'b0;
    chk("branch_pc", pc, 32'd4);

    repeat (14) step;
    chk("t5_req", 32'(m0.Mem_Req), 32'd1);
    chk("t5_err0", 32'(err), 32'd0);
    m0.Mem_Ack = 1'b1; m0.Mem_Data = 32'h600D;
    step;
    m0.Mem_Ack = 1'b0;
    chk("t5_we", 32'(we), 32'd1);
    chk("t5_ir", ir, 32'h600D);
    chk("t5_err", 32'(err), 32'd0);
    step;
    chk("t5_busy", 32'(busy), 32'd0);

    ld = 1'b1;
    step;
    ld = 1'b0;
    chk("t4_pc", pc, 32'd8);
    repeat (14) step;
    chk("t4_req14", 32'(m0.Mem_Req), 32'd1);
    chk("t4_err14", 32'(err), 32'd0);
    step;
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_req", 32'(m0.Mem_Req), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_we", 32'(we), 32'd0);
    ld = 1'b1; m0.Mem_Ack = 1'b1; m0.Mem_Data = 32'hBAD;
    repeat (3) step;
    chk("err_hold", 32'(err), 32'd1);
    chk("err_pc", pc, 32'd8);
    chk("err_ir", ir, 32'h600D);
    chk("err_req", 32'(m0.Mem_Req), 32'd0);
    chk("err_we", 32'(we), 32'd0);
    ld = 1'b0; m0.Mem_Ack = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("err_rst_err", 32'(err), 32'd0);
    chk("err_rst_busy", 32'(busy), 32'd1);
    chk("err_rst_pc", pc, 32'd0);
    chk("err_rst_ir", ir, 32'd0);
    chk("err_rst_req", 32'(m0.Mem_Req), 32'd0);

    step;
    fetch_ok(32'h11, 32'd0);
    ld = 1'b1; step; ld = 1'b0;
    fetch_ok(32'h22, 32'd4);
    ld = 1'b1; step; ld = 1'b0;
    fetch_ok(32'h33, 32'd8);
    ld = 1'b1; step; ld = 1'b0;
    chk("t6_pc", pc, 32'd12);
    chk("t6_req", 32'(m0.Mem_Req), 32'd1);
`ifdef IF_FETCH_CNT_EN
    chk("fcnt3", 32'(fcnt), 32'd3);
`endif
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("t6_rst_req", 32'(m0.Mem_Req), 32'd0);
    chk("t6_rst_pc", pc, 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd1);
`ifdef IF_FETCH_CNT_EN
    chk("fcnt_rst", 32'(fcnt), 32'd0);
`endif

    rst2 = 1'b0;
    step;
    chk("w_pc", pc2, 32'hFFFF_FFFC);
    chk("w_addr", m1.Mem_Addr, 32'hFFFF_FFFC);
    m1.Mem_Ack = 1'b1; m1.Mem_Data = 32'h77;
    step;
    m1.Mem_Ack = 1'b0;
    chk("w_we", 32'(we2), 32'd1);
    chk("w_ir", ir2, 32'h77);
    step;
    chk("w_busy", 32'(busy2), 32'd0);
    ld2 = 1'b1;
    step;
    ld2 = 1'b0;
    chk("w_wrap_pc", pc2, 32'd0);
    chk("w_wrap_addr", m1.Mem_Addr, 32'd0);
    chk("w_err", 32'(err2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
